// File: rtl/dircc_poets_tx.sv
// Serialises a buffered payload into one Avalon-ST packet: dest header, source header, then payload words.
// Latency: first beat in the cycle after send is accepted. Backpressure: ready low holds the current beat unchanged.
module dircc_poets_tx #(
    parameter int MAX_WORDS = 8,
    parameter int LEN_W     = 9
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic [31:0]                  node_address_address,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_WORDS)-1:0] wr_addr,
    input  logic [31:0]                  wr_data,
    input  logic                         send,
    input  logic [31:0]                  msg_dest,
    input  logic [LEN_W-1:0]             msg_len_bytes,
    output logic                         busy,
    output logic                         done,
    output logic                         send_err,
    output logic [31:0]                  output_poets_data,
    output logic                         output_poets_valid,
    input  logic                         output_poets_ready,
    output logic                         output_poets_startofpacket,
    output logic                         output_poets_endofpacket,
    output logic [1:0]                   output_poets_empty
);

    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(MAX_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE,
        HDR_DST,
        HDR_SRC,
        PAYLOAD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_buf [MAX_WORDS];
    logic [31:0]        r_dst;
    logic [31:0]        r_src;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_last_idx;
    logic               r_len_zero;
    logic [1:0]         r_empty;
    logic               r_done;
    logic               r_send_err;

    logic               w_idle;
    logic               w_send_ok;
    logic               w_send_bad;
    logic               w_fire;
    logic [31:0]        w_data;
    logic               w_valid;
    logic               w_sop;
    logic               w_eop;
    logic [1:0]         w_empty;

    assign w_idle     = (r_state == IDLE);
    assign w_send_ok  = w_idle && send && (msg_len_bytes <= MAX_BYTES);
    assign w_send_bad = w_idle && send && (msg_len_bytes > MAX_BYTES);
    assign w_fire     = w_valid && output_poets_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_data      = 32'd0;
        w_valid     = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_empty     = 2'd0;
        case (r_state)
            IDLE: begin
                if (w_send_ok) w_state_nxt = HDR_DST;
            end
            HDR_DST: begin
                w_valid = 1'b1;
                w_data  = r_dst;
                w_sop   = 1'b1;
                if (output_poets_ready) w_state_nxt = HDR_SRC;
            end
            HDR_SRC: begin
                w_valid = 1'b1;
                w_data  = r_src;
                w_eop   = r_len_zero;
                if (output_poets_ready) w_state_nxt = r_len_zero ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                w_valid = 1'b1;
                w_data  = r_buf[r_idx];
                w_eop   = (r_idx == r_last_idx);
                w_empty = w_eop ? r_empty : 2'd0;
                if (output_poets_ready && w_eop) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_dst      <= 32'd0;
            r_src      <= 32'd0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_len_zero <= 1'b0;
            r_empty    <= 2'd0;
            r_done     <= 1'b0;
            r_send_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_fire && w_eop;
            r_send_err <= w_send_bad;
            if (w_send_ok) begin
                r_dst      <= msg_dest;
                r_src      <= node_address_address;
                r_idx      <= '0;
                // ceil(len/4)-1 == (len-1)/4 for len >= 1; unused when len is zero
                r_last_idx <= IDX_W'((msg_len_bytes - LEN_W'(1)) >> 2);
                r_len_zero <= (msg_len_bytes == '0);
                r_empty    <= 2'd0 - msg_len_bytes[1:0];
            end else if (r_state == PAYLOAD && output_poets_ready) begin
                r_idx      <= r_idx + IDX_W'(1);
            end
        end
    end

    // Buffer is locked while a packet is in flight, so payload reads stay stable across stalls
    always_ff @(posedge clk_clk) begin
        if (wr_en && w_idle) r_buf[wr_addr] <= wr_data;
    end

    assign busy                       = !w_idle;
    assign done                       = r_done;
    assign send_err                   = r_send_err;
    assign output_poets_data          = w_data;
    assign output_poets_valid         = w_valid;
    assign output_poets_startofpacket = w_sop;
    assign output_poets_endofpacket   = w_eop;
    assign output_poets_empty         = w_empty;

endmodule

// File: tb/tb_dircc_poets_tx.sv
// Bench for dircc_poets_tx: a queue-of-beats packet model checked every cycle, plus literal beat checks.
module tb_dircc_poets_tx;

    localparam int MW = 8;
    localparam int LW = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] node_addr = 32'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic        send = 1'b0;
    logic [31:0] dest = 32'd0;
    logic [LW-1:0] len = '0;
    logic        ready = 1'b1;
    bit          rand_mode = 1'b0;
    bit          cmp_en = 1'b0;

    logic        busy, done, send_err, valid, sop, eop;
    logic [31:0] data;
    logic [1:0]  empty;

    always #5 clk = ~clk;

    dircc_poets_tx #(.MAX_WORDS(MW), .LEN_W(LW)) dut (
        .clk_clk                    (clk),
        .reset_reset_n              (rst_n),
        .node_address_address       (node_addr),
        .wr_en                      (wr_en),
        .wr_addr                    (wr_addr),
        .wr_data                    (wr_data),
        .send                       (send),
        .msg_dest                   (dest),
        .msg_len_bytes              (len),
        .busy                       (busy),
        .done                       (done),
        .send_err                   (send_err),
        .output_poets_data          (data),
        .output_poets_valid         (valid),
        .output_poets_ready         (ready),
        .output_poets_startofpacket (sop),
        .output_poets_endofpacket   (eop),
        .output_poets_empty         (empty)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    beat_t       log_q[$];
    logic [31:0] mem [MW];
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;
    int          checks = 0;
    int          fails  = 0;

    function automatic beat_t mk(logic s, logic e, logic [1:0] em, logic [31:0] d);
        beat_t b;
        b = {s, e, em, d};
        return b;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: an accepted send expands into its full list of beats up front
    always @(posedge clk or negedge rst_n) begin
        bit    idle;
        beat_t b;
        int    nw;
        int    l;
        if (!rst_n) begin
            q.delete();
            exp_done = 1'b0;
            exp_err  = 1'b0;
        end else begin
            idle     = (q.size() == 0);
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (!idle && ready === 1'b1) begin
                b = q.pop_front();
                exp_done = b.eop;
            end
            if (idle) begin
                if (wr_en === 1'b1) mem[wr_addr] = wr_data;
                if (send === 1'b1) begin
                    l = int'(len);
                    if (l > MW * 4) begin
                        exp_err = 1'b1;
                    end else begin
                        nw = (l + 3) / 4;
                        q.push_back(mk(1'b1, 1'b0, 2'd0, dest));
                        q.push_back(mk(1'b0, l == 0, 2'd0, node_addr));
                        for (int i = 0; i < nw; i++)
                            q.push_back(mk(1'b0, i == nw - 1,
                                           (i == nw - 1) ? 2'((4 - l % 4) % 4) : 2'd0, mem[i]));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        logic  ev;
        if (cmp_en) begin
            ev = (q.size() != 0);
            e  = ev ? q[0] : beat_t'(0);
            chk("cycle_outputs",
                64'({busy, done, send_err, valid, sop, eop, empty, data}),
                64'({ev, exp_done, exp_err, ev, e.sop, e.eop, e.empty, e.data}));
            if (valid === 1'b1 && ready === 1'b1) log_q.push_back(beat_t'({sop, eop, empty, data}));
        end
    end

    always @(posedge clk) begin
        #1;
        ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [31:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_send(logic [31:0] d, int l);
        dest = d; len = LW'(l); send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic wait_done(int budget, string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (done !== 1'b1) chk({name, "_timeout"}, 64'(done), 64'(1));
        else               chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        chk("reset_outputs", 64'({busy, done, send_err, valid, sop, eop, empty, data}), 64'(0));
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic 5-byte packet
        node_addr = 32'h00030004;
        wr(0, 32'h11111111);
        wr(1, 32'h22222222);
        log_q.delete();
        do_send(32'h00010002, 5);
        wait_done(20, "t1");
        step();
        chk("t1_done_one_cycle", 64'(done), 64'(0));
        chk("t1_count", 64'(log_q.size()), 64'(4));
        chk("t1_b0", 64'(log_q[0]), 64'(mk(1'b1, 1'b0, 2'd0, 32'h00010002)));
        chk("t1_b1", 64'(log_q[1]), 64'(mk(1'b0, 1'b0, 2'd0, 32'h00030004)));
        chk("t1_b2", 64'(log_q[2]), 64'(mk(1'b0, 1'b0, 2'd0, 32'h11111111)));
        chk("t1_b3", 64'(log_q[3]), 64'(mk(1'b0, 1'b1, 2'd3, 32'h22222222)));

        // Zero-length packet
        log_q.delete();
        do_send(32'h00050006, 0);
        wait_done(20, "t2");
        chk("t2_count", 64'(log_q.size()), 64'(2));
        chk("t2_b0", 64'(log_q[0]), 64'(mk(1'b1, 1'b0, 2'd0, 32'h00050006)));
        chk("t2_b1", 64'(log_q[1]), 64'(mk(1'b0, 1'b1, 2'd0, 32'h00030004)));

        // Full buffer with random backpressure
        for (int i = 0; i < MW; i++) wr(i, 32'hA0000000 + 32'(i));
        log_q.delete();
        rand_mode = 1'b1;
        do_send(32'hDEAD0001, 32);
        wait_done(400, "t3");
        rand_mode = 1'b0;
        step();
        chk("t3_count", 64'(log_q.size()), 64'(10));
        chk("t3_b0", 64'(log_q[0]), 64'(mk(1'b1, 1'b0, 2'd0, 32'hDEAD0001)));
        for (int i = 0; i < MW; i++)
            chk("t3_payload", 64'(log_q[2 + i].data), 64'(32'hA0000000 + 32'(i)));
        chk("t3_last", 64'(log_q[9]), 64'(mk(1'b0, 1'b1, 2'd0, 32'hA0000007)));

        // Over-range length rejected
        do_send(32'h00000077, 33);
        chk("t4_err_pulse", 64'(send_err), 64'(1));
        chk("t4_idle", 64'({valid, busy}), 64'(0));
        step();
        chk("t4_err_once", 64'(send_err), 64'(0));

        // Send and write while busy are ignored
        wr(0, 32'hC0C0C0C0);
        wr(1, 32'hC1C1C1C1);
        log_q.delete();
        do_send(32'h00A0000B, 8);
        send = 1'b1; dest = 32'h00000BAD; len = LW'(4);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFFFFFF;
        step();
        send = 1'b0; wr_en = 1'b0;
        wait_done(20, "t5");
        chk("t5_count", 64'(log_q.size()), 64'(4));
        chk("t5_dest", 64'(log_q[0].data), 64'(32'h00A0000B));
        chk("t5_w0", 64'(log_q[2].data), 64'(32'hC0C0C0C0));
        step();
        log_q.delete();
        do_send(32'h00000001, 4);
        wait_done(20, "t5b");
        chk("t5_w0_kept", 64'(log_q[2]), 64'(mk(1'b0, 1'b1, 2'd0, 32'hC0C0C0C0)));

        // Asynchronous reset during a payload beat
        for (int i = 0; i < 4; i++) wr(i, 32'hD0 + 32'(i));
        do_send(32'h0000000E, 16);
        step();
        step();
        chk("t6_pre_reset", 64'({valid, sop, data}), 64'({1'b1, 1'b0, 32'hD0}));
        #2 rst_n = 1'b0;
        #1 chk("t6_async_reset", 64'({busy, done, send_err, valid, sop, eop, empty, data}), 64'(0));
        step(); step();
        rst_n = 1'b1;
        step();
        wr(0, 32'hE0);
        wr(1, 32'hE1);
        log_q.delete();
        do_send(32'h0000000F, 6);
        wait_done(20, "t6");
        chk("t6_count", 64'(log_q.size()), 64'(4));
        chk("t6_b0", 64'(log_q[0]), 64'(mk(1'b1, 1'b0, 2'd0, 32'h0000000F)));
        chk("t6_last", 64'(log_q[3]), 64'(mk(1'b0, 1'b1, 2'd2, 32'hE1)));

        step(); step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d fails %0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
